// File: rtl/avr_bus_master.sv
// avr_bus_master
// ---------------------------------------------------------------------------
// Host-side protocol engine for the AVR<->SRAM bus of the CPLD. It turns
// parallel host commands into the pin protocol used by the CPLD: a serial
// address shift on avr_si, the address enable avr_sreg_en, the active-low
// read/write strobes avr_oe/avr_we, and the active-low address increment
// pulse avr_counter.
//
// Ports
//   avr_clk      : clock; all logic on the rising edge
//   avr_reset_n  : asynchronous active-low reset
//   cmd_valid    : host command request
//   cmd_ready    : high only while idle; accept = cmd_valid && cmd_ready
//   cmd_op       : 00 SET_ADDR, 01 READ, 10 WRITE, 11 INC
//   cmd_addr     : address for SET_ADDR (shifted MSB first)
//   cmd_wdata    : write data for WRITE
//   rsp_valid    : one-cycle pulse when any command completes
//   rsp_data     : last byte read; updated only when a READ completes
//   avr_si       : serial address bit
//   avr_sreg_en  : 0 while shifting, 1 once the address has been latched
//   avr_oe       : active-low read strobe
//   avr_we       : active-low write strobe
//   avr_counter  : active-low address increment pulse
//   avr_data     : bidirectional data bus, driven only during WRITE
//
// Every pin-level output is registered. Next-cycle output values are decoded
// from the next state so that outputs line up with the state they belong to.
// ---------------------------------------------------------------------------
module avr_bus_master #(
    parameter int ADDR_W  = 16,
    parameter int SCK_DIV = 4,
    parameter int STROBE  = 4
) (
    input  logic              avr_clk,
    input  logic              avr_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [7:0]        cmd_wdata,
    output logic              rsp_valid,
    output logic [7:0]        rsp_data,
    output logic              avr_si,
    output logic              avr_sreg_en,
    output logic              avr_oe,
    output logic              avr_we,
    output logic              avr_counter,
    inout  wire  [7:0]        avr_data
);

    localparam int BIT_W = (ADDR_W  > 1) ? $clog2(ADDR_W)  : 1;
    localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
    localparam int STB_W = (STROBE  > 1) ? $clog2(STROBE)  : 1;

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(ADDR_W - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCK_DIV - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STROBE - 1);

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_READ = 2'b01;
    localparam logic [1:0] OP_WRIT = 2'b10;
    localparam logic [1:0] OP_INC  = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_SHIFT  = 4'd1,
        S_LATCH  = 4'd2,
        S_RD     = 4'd3,
        S_WR     = 4'd4,
        S_TURN   = 4'd5,
        S_INC_LO = 4'd6,
        S_INC_HI = 4'd7,
        S_DONE   = 4'd8
    } state_t;

    state_t            state_r, state_s;
    logic [BIT_W-1:0]  bit_r, bit_s;
    logic [DIV_W-1:0]  div_r, div_s;
    logic [STB_W-1:0]  stb_r, stb_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [7:0]        wdata_r, wdata_s;
    logic [7:0]        rdata_r, rdata_s;

    logic oe_r, oe_s;
    logic we_r, we_s;
    logic cnt_r, cnt_s;
    logic si_r, si_s;
    logic sreg_r, sreg_s;
    logic drive_r, drive_s;
    logic rsp_valid_r, rsp_valid_s;
    logic ready_r, ready_s;

    // FSM state register
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state, counters and command/read data capture
    always_comb begin
        state_s = state_r;
        bit_s   = bit_r;
        div_s   = div_r;
        stb_s   = stb_r;
        addr_s  = addr_r;
        wdata_s = wdata_r;
        rdata_s = rdata_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_valid) begin
                    addr_s  = cmd_addr;
                    wdata_s = cmd_wdata;
                    case (cmd_op)
                        OP_SET:  state_s = S_SHIFT;
                        OP_READ: state_s = S_RD;
                        OP_WRIT: state_s = S_WR;
                        OP_INC:  state_s = S_INC_LO;
                        default: state_s = S_IDLE;
                    endcase
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                // addr_r is consumed as a shift register: its MSB is the bit on avr_si
                if (div_r == DIV_LAST) begin
                    div_s  = {DIV_W{1'b0}};
                    addr_s = addr_r << 1;
                    if (bit_r == BIT_LAST) begin
                        bit_s   = {BIT_W{1'b0}};
                        state_s = S_LATCH;
                    end else begin
                        bit_s = bit_r + 1'b1;
                    end
                end else begin
                    div_s = div_r + 1'b1;
                end
            end
            S_LATCH: state_s = S_DONE;
            S_RD: begin
                if (stb_r == STB_LAST) begin
                    stb_s   = {STB_W{1'b0}};
                    rdata_s = avr_data;
                    state_s = S_DONE;
                end else begin
                    stb_s = stb_r + 1'b1;
                end
            end
            S_WR: begin
                if (stb_r == STB_LAST) begin
                    stb_s   = {STB_W{1'b0}};
                    state_s = S_TURN;
                end else begin
                    stb_s = stb_r + 1'b1;
                end
            end
            S_TURN:   state_s = S_DONE;
            S_INC_LO: state_s = S_INC_HI;
            S_INC_HI: state_s = S_DONE;
            S_DONE:   state_s = S_IDLE;
            default:  state_s = S_IDLE;
        endcase
    end

    // Pin values for the coming cycle, decoded from the next state
    always_comb begin
        oe_s        = 1'b1;
        we_s        = 1'b1;
        cnt_s       = 1'b1;
        si_s        = 1'b0;
        sreg_s      = sreg_r;
        drive_s     = 1'b0;
        rsp_valid_s = 1'b0;
        ready_s     = 1'b0;
        case (state_s)
            S_IDLE:   ready_s = 1'b1;
            S_SHIFT: begin
                si_s   = addr_s[ADDR_W-1];
                sreg_s = 1'b0;
            end
            S_LATCH:  sreg_s = 1'b1;
            S_RD:     oe_s   = 1'b0;
            S_WR: begin
                we_s    = 1'b0;
                drive_s = 1'b1;
            end
            // data is held one cycle past the strobe so the SRAM sees a clean hold time
            S_TURN:   drive_s = 1'b1;
            S_INC_LO: cnt_s   = 1'b0;
            S_INC_HI: cnt_s   = 1'b1;
            S_DONE:   rsp_valid_s = 1'b1;
            default:  ready_s = 1'b0;
        endcase
    end

    // Datapath and registered pin outputs
    always_ff @(posedge avr_clk or negedge avr_reset_n) begin
        if (!avr_reset_n) begin
            bit_r       <= {BIT_W{1'b0}};
            div_r       <= {DIV_W{1'b0}};
            stb_r       <= {STB_W{1'b0}};
            addr_r      <= {ADDR_W{1'b0}};
            wdata_r     <= 8'h00;
            rdata_r     <= 8'h00;
            oe_r        <= 1'b1;
            we_r        <= 1'b1;
            cnt_r       <= 1'b1;
            si_r        <= 1'b0;
            sreg_r      <= 1'b0;
            drive_r     <= 1'b0;
            rsp_valid_r <= 1'b0;
            ready_r     <= 1'b1;
        end else begin
            bit_r       <= bit_s;
            div_r       <= div_s;
            stb_r       <= stb_s;
            addr_r      <= addr_s;
            wdata_r     <= wdata_s;
            rdata_r     <= rdata_s;
            oe_r        <= oe_s;
            we_r        <= we_s;
            cnt_r       <= cnt_s;
            si_r        <= si_s;
            sreg_r      <= sreg_s;
            drive_r     <= drive_s;
            rsp_valid_r <= rsp_valid_s;
            ready_r     <= ready_s;
        end
    end

    assign cmd_ready   = ready_r;
    assign rsp_valid   = rsp_valid_r;
    assign rsp_data    = rdata_r;
    assign avr_si      = si_r;
    assign avr_sreg_en = sreg_r;
    assign avr_oe      = oe_r;
    assign avr_we      = we_r;
    assign avr_counter = cnt_r;
    assign avr_data    = drive_r ? wdata_r : 8'hzz;

endmodule

// File: doc/avr_bus_master.md
Name: avr_bus_master

Overview:
- AVR-side initiator for the CPLD's AVR↔SRAM bus; drives the opposite end of the `system` AVR interface.
- Converts parallel host commands into the pin protocol: serial address shift on `avr_si`, address enable via `avr_sreg_en`, read/write strobes `avr_oe`/`avr_we`, and address increment via `avr_counter`.
- Used as the host-side protocol engine and as the bus-functional driver in `system`-level benches.

Parameters:
- ADDR_W, 16, address bits shifted per SET_ADDR, MSB first.
- SCK_DIV, 4, avr_clk cycles each serial bit is held on avr_si.
- STROBE, 4, avr_clk cycles avr_oe/avr_we are held low per access.

Ports:
- avr_clk  input  1  system clock; all logic on rising edge.
- avr_reset_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  host command request.
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid && cmd_ready.
- cmd_op  input  2  00 SET_ADDR, 01 READ, 10 WRITE, 11 INC.
- cmd_addr  input  ADDR_W  address for SET_ADDR.
- cmd_wdata  input  8  write data for WRITE.
- rsp_valid  output  1  one-cycle pulse on completion of any command.
- rsp_data  output  8  read byte; valid with rsp_valid after READ, holds until next READ completes.
- avr_si  output  1  serial address bit to the shift register.
- avr_sreg_en  output  1  0 while shifting; 1 = shift register drives the SRAM address.
- avr_oe  output  1  active-low read strobe.
- avr_we  output  1  active-low write strobe.
- avr_counter  output  1  active-low increment pulse.
- avr_data  inout  8  AVR data bus; driven only during WRITE, else high-Z.

Behaviour:
- Reset, asynchronous, any state:
  - Outputs: avr_oe=1, avr_we=1, avr_counter=1, avr_si=0, avr_sreg_en=0, avr_data=Z, rsp_valid=0, rsp_data=00, cmd_ready=1, FSM→IDLE.
  - Reset mid-operation aborts with no rsp_valid.
- FSM states: IDLE, SHIFT, LATCH, RD, WR, TURN, INC_LO, INC_HI, DONE.
- IDLE: cmd_ready=1; on accept, latch cmd_addr/cmd_wdata and go to SHIFT, RD, WR or INC_LO per cmd_op.
- SHIFT:
  - avr_sreg_en=0.
  - avr_si = addr[ADDR_W-1-k] for bit k, held exactly SCK_DIV cycles. Bit counter 0..ADDR_W-1; divider 0..SCK_DIV-1.
  - Total ADDR_W*SCK_DIV cycles (64 at defaults), then LATCH.
- LATCH: one cycle; avr_si=0, avr_sreg_en=1 → DONE. avr_sreg_en stays 1 until the next SET_ADDR enters SHIFT.
- RD:
  - avr_oe=0 for STROBE cycles.
  - avr_data sampled into rsp_data on the last strobe cycle.
  - Then DONE; avr_oe=1 in DONE.
- WR:
  - avr_we=0 and avr_data=wdata for STROBE cycles.
  - Then TURN: one cycle with avr_we=1 and avr_data still driven (hold).
  - Then DONE; avr_data=Z from DONE onward.
- INC_LO: avr_counter=0 for one cycle. INC_HI: avr_counter=1 for one cycle. Then DONE.
- DONE:
  - rsp_valid=1 for one cycle, cmd_ready=0 → IDLE.
  - Minimum gap between commands is therefore 1 IDLE cycle. This guarantees avr_data is released ≥2 cycles before any following avr_oe=0.
- Accept latency: SET_ADDR completes in ADDR_W*SCK_DIV+2 cycles; READ in STROBE+1; WRITE in STROBE+2; INC in 3.
- Invariants:
  - avr_oe and avr_we are never low simultaneously.
  - avr_data is never driven while avr_oe=0.
  - No strobe occurs during SHIFT.
- cmd_valid while cmd_ready=0: ignored, not queued; host must hold cmd_valid.
- READ/WRITE/INC before any SET_ADDR are legal. avr_sreg_en remains 0 in that case; address is undefined.
- Bit/divider counters wrap to 0 on exit from SHIFT. Counter widths are sized by $clog2 of the parameters.
- rsp_data is unchanged by SET_ADDR, WRITE and INC.

Test Plan:
- Reset then SET_ADDR 0x9933 → avr_si shows 1001100100110011 MSB first, each bit 4 cycles. avr_sreg_en=0 during the 64 shift cycles, rises at LATCH. rsp_valid on cycle 66 after accept.
- READ with bench driving avr_data=0xAA → avr_oe low exactly 4 cycles, avr_we=1 throughout, rsp_data=0xAA with rsp_valid. Back-to-back READ returning 0xBB → rsp_data=0xBB.
- WRITE 0xEE → avr_we low 4 cycles, avr_data=0xEE from the first strobe cycle through TURN, Z in DONE. Following READ of 0x22 sees avr_oe low only after avr_data is Z; rsp_data=0x22.
- INC → avr_counter=0 exactly one cycle, then 1; rsp_valid 3 cycles after accept. Other outputs unchanged.
- Assert avr_reset_n low mid-SHIFT (bit 5) and mid-WR (strobe cycle 2) → all outputs return to reset values asynchronously, avr_data=Z, no rsp_valid. A new SET_ADDR after release shifts from bit 15.
- Hold cmd_valid during a busy READ with cmd_op=WRITE → WRITE accepted only in the IDLE cycle after DONE. Assertion checks for oe/we overlap and driven-data-during-oe are never violated.
